// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory access controller
package imem_pkg;

    localparam int IMEM_ADDR_W  = 5;
    localparam int IMEM_DATA_W  = 32;
    localparam int IMEM_PC_W    = 64;
    localparam int BYTE_OFF_W   = 2;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_arb_rr_starve.sv
// rtl/imem_arb_rr_starve.sv - fetch-priority two-requester arbiter with loader starvation bound
module imem_arb_rr_starve
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_f,
    input  logic req_l,
    output logic gnt_f,
    output logic gnt_l
);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    starved;

    always_comb begin
        starved      = (starve_cnt_q >= STARVE_CNT_W'(STARVE_MAX));
        gnt_f        = req_f & ~(req_l & starved);
        gnt_l        = req_l & ~gnt_f;
        starve_cnt_d = starve_cnt_q;
        // Count only fetch wins that pushed a waiting loader aside
        if (!req_l || gnt_l) begin
            starve_cnt_d = '0;
        end else if (gnt_f) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/imem_access_ctrl.sv
// rtl/imem_access_ctrl.sv - BOOT/RUN sequencer and port arbiter for the instruction memory
// Optional loader checksum/count outputs enabled by IMEM_LOAD_CHECKSUM_EN.
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int PC_W       = IMEM_PC_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault,
    output logic              cpu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [DATA_W-1:0] ld_checksum,
    output logic [ADDR_W:0]   ld_count,
`endif
    output logic              booted
);

    imem_state_e       state_q, state_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
    logic              fetch_fault_q, fetch_fault_d;

    logic              run;
    logic              gnt_f;
    logic              gnt_l;
    logic              fetch_bad;
    logic [ADDR_W-1:0] fetch_word;

    assign run        = (state_q == ST_RUN);
    assign fetch_word = fetch_pc[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
    assign fetch_bad  = (|fetch_pc[BYTE_OFF_W-1:0]) | (|fetch_pc[PC_W-1:ADDR_W+BYTE_OFF_W]);

    imem_arb_rr_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_f (fetch_req & run),
        .req_l (ld_valid & run),
        .gnt_f (gnt_f),
        .gnt_l (gnt_l)
    );

    always_comb begin
        state_d       = state_q;
        ld_ready      = 1'b0;
        mem_addr      = ld_addr;
        cpu_stall     = 1'b1;
        fetch_valid_d = 1'b0;
        fetch_fault_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        if (!run) begin
            ld_ready = ld_valid;
            // A write accepted alongside ld_done lands first; RUN follows once the stream is idle
            if (ld_done && !ld_valid) begin
                state_d = ST_RUN;
            end
        end else begin
            ld_ready  = gnt_l;
            cpu_stall = fetch_req & ~gnt_f;
            if (gnt_f) begin
                mem_addr      = fetch_word;
                fetch_valid_d = 1'b1;
                fetch_fault_d = fetch_bad;
                fetch_instr_d = fetch_bad ? '0 : mem_rdata;
            end
        end
        // Reset kills any in-flight strobe without waiting for the clock
        if (rst) begin
            ld_ready = 1'b0;
        end
    end

    assign mem_we      = ld_ready;
    assign mem_wdata   = ld_data;
    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_fault = fetch_fault_q;
    assign booted      = run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    localparam logic [ADDR_W:0] LD_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] ld_checksum_q, ld_checksum_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;

    always_comb begin
        ld_checksum_d = ld_checksum_q;
        ld_count_d    = ld_count_q;
        if (ld_ready) begin
            ld_checksum_d = ld_checksum_q ^ ld_data;
            if (ld_count_q != LD_COUNT_MAX) begin
                ld_count_d = ld_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_checksum_q <= '0;
            ld_count_q    <= '0;
        end else begin
            ld_checksum_q <= ld_checksum_d;
            ld_count_q    <= ld_count_d;
        end
    end

    assign ld_checksum = ld_checksum_q;
    assign ld_count    = ld_count_q;
`endif

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequences and arbitrates the single port of the 32x32 instruction memory between two requesters: the CPU fetch stage (PC-driven reads) and a program loader (valid/ready write stream).
- After reset the block holds the CPU in a BOOT phase while the loader fills memory, then enters RUN with fetch priority and bounded loader starvation.
- Sits between the PC register / fetch stage and the instruction memory array; the memory array itself stays combinational-read, level-write.

Parameters:
- ADDR_W, 5, word-address width of the instruction memory (depth 2**ADDR_W).
- DATA_W, 32, instruction width.
- PC_W, 64, PC width.
- STARVE_MAX, 4, max consecutive fetch grants while a loader write is pending before the loader is forced a slot (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  CPU requests an instruction this cycle.
- fetch_pc  in  PC_W  byte address of the requested instruction.
- fetch_valid  out  1  fetch_instr/fetch_fault valid (one-cycle pulse per granted fetch).
- fetch_instr  out  DATA_W  registered instruction.
- fetch_fault  out  1  granted fetch was misaligned or out of range.
- cpu_stall  out  1  fetch not granted this cycle (BOOT, or loader slot taken).
- ld_valid  in  1  loader write present.
- ld_ready  out  1  loader write accepted this cycle (combinational from state/arbitration).
- ld_addr  in  ADDR_W  word address of loader write.
- ld_data  in  DATA_W  loader write data.
- ld_done  in  1  loader signals program complete (level or pulse).
- mem_addr  out  ADDR_W  memory word address.
- mem_we  out  1  memory write strobe (one cycle).
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.
- booted  out  1  high once in RUN.

Behaviour:
- Reset values: state=BOOT, fetch_valid=0, fetch_instr=0, fetch_fault=0, booted=0, starve_cnt=0; combinational outputs resolve from state (cpu_stall=1, mem_we=0).
- States: BOOT -> RUN when ld_done=1 and no loader transfer accepted that cycle (a write accepted in the same cycle as ld_done completes first; transition next cycle). RUN is terminal until reset.
- BOOT: ld_ready=ld_valid; mem_we=ld_valid; mem_addr=ld_addr; cpu_stall=1; fetch_req ignored, no fetch_valid.
- RUN arbitration per cycle:
  - fetch_req only -> fetch granted.
  - ld_valid only -> write granted.
  - Both, starve_cnt<STARVE_MAX -> fetch granted, starve_cnt++.
  - Both, starve_cnt=STARVE_MAX -> write granted, cpu_stall=1.
  - starve_cnt clears whenever a write is granted or ld_valid=0.
- Fetch address: word index = fetch_pc[ADDR_W+1:2]. fault if fetch_pc[1:0]!=0 or any fetch_pc[PC_W-1:ADDR_W+2]!=0.
- Fetch latency 1: on grant, next cycle fetch_valid=1, fetch_instr=mem_rdata sampled at grant edge (0 if fault), fetch_fault as computed. Back-to-back grants give back-to-back fetch_valid.
- Write is single-cycle: mem_we high only in the grant cycle; write visible to a fetch granted the following cycle (same-address RAW returns new data).
- Same cycle fetch and write to same address: only one is granted per the rules above; never both.
- rst asserted mid-load or mid-fetch: immediate return to BOOT, pending fetch_valid dropped, in-flight write strobe deasserted; memory contents not cleared.

Optional Feature:
- Macro IMEM_LOAD_CHECKSUM_EN.
- Defined: extra output ld_checksum [DATA_W-1:0], reset 0, XOR-accumulates ld_data on every accepted loader write (BOOT and RUN); extra output ld_count [ADDR_W:0] counting accepted writes, saturating at 2**ADDR_W.
- Undefined: ports absent, no accumulator logic.

Decomposition:
- Shared package imem_pkg: state enum (BOOT, RUN), IMEM_ADDR_W=5, IMEM_DATA_W=32, PC_W=64, word-index slice helper constant (byte-offset bits = 2).
- One natural sub-module: imem_arb_rr_starve, the two-requester fixed-priority arbiter with starvation counter (inputs req_f, req_l; outputs gnt_f, gnt_l).

Test Plan:
- Reset, then loader writes addr0=0x8B020020, addr1=0xCB020020, ld_done -> mem_we pulses twice, booted=1 cycle after, cpu_stall=0 in RUN.
- RUN, fetch_req with fetch_pc=0x4 -> next cycle fetch_valid=1, fetch_instr=0xCB020020, fetch_fault=0.
- fetch_pc=0x6 and fetch_pc=0x100 -> fetch_valid=1, fetch_fault=1, fetch_instr=0.
- fetch_req and ld_valid held high, STARVE_MAX=4 -> 4 fetch grants, then 1 write grant with cpu_stall=1, pattern repeats.
- Write addr2=0x12345678 in cycle N, fetch pc=0x8 in N+1 -> fetch_instr=0x12345678 at N+2.
- fetch_req during BOOT -> no fetch_valid, cpu_stall=1; rst asserted during RUN write -> mem_we=0 immediately, booted=0.
